// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision register-exchange Viterbi decoder, rate 1/2, K=3 (7/5)
//
// Purpose:
//    Decodes one 2-bit code symbol per enabled cycle and emits one decoded
//    information bit per enabled cycle, TB_DEPTH symbols late. The matching
//    encoder holds state {s1,s2} (s1 = newest bit), sends {u^s1^s2, u^s2}
//    and moves to {u,s1}, starting from state 0.
//
// Parameters:
//    TB_DEPTH  survivor register length = decode latency in symbols (>= 2)
//    METRIC_W  path-metric width in bits (>= 4)
//
// Ports:
//    clk     in   1  clock, rising edge
//    rst     in   1  asynchronous active-low reset
//    enable  in   1  qualifies d_in; one symbol consumed per enabled cycle
//    d_in    in   2  code symbol {g7 bit, g5 bit}
//    d_out   out  1  decoded information bit, registered
//
// Configuration macro:
//    VITERBI_BEST_STATE_EN  defined   -> output taken from the best-metric state
//                           undefined -> output taken from state 0 (fixed-state decode)

module viterbi_decoder #(
   parameter int TB_DEPTH = 16,
   parameter int METRIC_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] d_in,
   output logic       d_out
);

   localparam logic [METRIC_W-1:0] PM_INIT = {2'b01, {(METRIC_W-2){1'b0}}};
   localparam logic [METRIC_W:0]   PM_SAT  = {1'b0, {METRIC_W{1'b1}}};

   logic [METRIC_W-1:0] pm   [4];
   logic [TB_DEPTH-1:0] surv [4];

   logic [METRIC_W:0]   cand0  [4];
   logic [METRIC_W:0]   cand1  [4];
   logic [METRIC_W:0]   new_pm [4];
   logic [METRIC_W-1:0] norm_pm[4];
   logic [1:0]          pred   [4];
   logic [METRIC_W:0]   min_01;
   logic [METRIC_W:0]   min_23;
   logic [METRIC_W:0]   min_pm;
   logic [METRIC_W:0]   diff_pm[4];
   logic [1:0]          pred_w;

   // Hamming distance between the received symbol and the symbol the encoder
   // would have sent from state s on input u.
   function automatic logic [1:0] branch_metric(input logic [1:0] s,
                                                input logic       u,
                                                input logic [1:0] sym);
      logic [1:0] expect_sym;
      logic [1:0] diff;
      expect_sym = {u ^ s[1] ^ s[0], u ^ s[0]};
      diff       = expect_sym ^ sym;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   // Add-compare-select. Next state ns = {u,s1} is reached from {s1,0} or {s1,1}
   // with input u = ns[1]. Candidates carry one extra bit so the add cannot wrap.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cand0[i]  = {1'b0, pm[{i[0], 1'b0}]}
                   + {{(METRIC_W-1){1'b0}}, branch_metric({i[0], 1'b0}, i[1], d_in)};
         cand1[i]  = {1'b0, pm[{i[0], 1'b1}]}
                   + {{(METRIC_W-1){1'b0}}, branch_metric({i[0], 1'b1}, i[1], d_in)};
         // Strict compare: a tie keeps the s2=0 predecessor.
         if (cand1[i] < cand0[i]) begin
            new_pm[i] = cand1[i];
            pred[i]   = {i[0], 1'b1};
         end else begin
            new_pm[i] = cand0[i];
            pred[i]   = {i[0], 1'b0};
         end
      end
   end

   // Normalise against the smallest new metric, then clamp to the register
   // range so a far-behind path sticks at the ceiling instead of wrapping.
   always_comb begin
      min_01 = (new_pm[1] < new_pm[0]) ? new_pm[1] : new_pm[0];
      min_23 = (new_pm[3] < new_pm[2]) ? new_pm[3] : new_pm[2];
      min_pm = (min_23 < min_01) ? min_23 : min_01;
      for (int i = 0; i < 4; i++) begin
         diff_pm[i] = new_pm[i] - min_pm;
         if (diff_pm[i] > PM_SAT) begin
            norm_pm[i] = PM_SAT[METRIC_W-1:0];
         end else begin
            norm_pm[i] = diff_pm[i][METRIC_W-1:0];
         end
      end
   end

`ifdef VITERBI_BEST_STATE_EN
   logic [1:0] best_state;

   // Lowest index wins ties because only a strictly smaller metric replaces it.
   always_comb begin
      best_state = 2'd0;
      for (int i = 1; i < 4; i++) begin
         if (new_pm[i] < new_pm[best_state]) begin
            best_state = 2'(i);
         end
      end
      pred_w = pred[best_state];
   end
`else
   // Fixed-state decode: follow whatever path survives into state 0.
   always_comb begin
      pred_w = pred[0];
   end
`endif

   // Register exchange: each next state inherits its chosen predecessor's
   // history and appends its own newest bit (ns[1] = u). The bit pushed out of
   // the winning history is the decision for the symbol TB_DEPTH steps back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pm[0] <= '0;
         for (int i = 1; i < 4; i++) begin
            pm[i] <= PM_INIT;
         end
         for (int i = 0; i < 4; i++) begin
            surv[i] <= '0;
         end
         d_out <= 1'b0;
      end else if (enable) begin
         for (int i = 0; i < 4; i++) begin
            pm[i]   <= norm_pm[i];
            surv[i] <= {surv[pred[i]][TB_DEPTH-2:0], i[1]};
         end
         d_out <= surv[pred_w][TB_DEPTH-1];
      end
   end

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - scoreboard bench for viterbi_decoder
module tb_viterbi_decoder;

   localparam int TB_DEPTH = 16;
   localparam int METRIC_W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [1:0] d_in = 2'b00;
   logic       d_out;

   always #5 clk = ~clk;

   viterbi_decoder #(
      .TB_DEPTH(TB_DEPTH),
      .METRIC_W(METRIC_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .d_in  (d_in),
      .d_out (d_out)
   );

   typedef struct {
      logic bit_v;
      logic tol;
   } exp_t;

   exp_t exp_q[$];
   logic u_hist[$];
   logic [1:0] enc_st = 2'b00;
   int n_cmp = 0;
   int n_err = 0;
   int tol_err = 0;
   int tol_lo = -1000;
   int tol_hi = -1000;
   logic last_exp = 1'b0;
   bit zero_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
      end
   endtask

   // Monitor: samples the enable/reset state seen by each rising edge, then
   // inspects d_out 1 time unit later.
   initial begin
      logic en_s;
      logic rst_s;
      exp_t e;
      forever begin
         @(posedge clk);
         en_s  = enable;
         rst_s = rst;
         #1;
         if (!rst_s) begin
            check("reset_d_out", {31'd0, d_out}, 32'd0);
            last_exp = 1'b0;
         end else if (en_s) begin
            if (exp_q.size() == 0) begin
               check("queue_underflow", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.tol) begin
                  if (d_out !== e.bit_v) tol_err++;
               end else begin
                  check("d_out", {31'd0, d_out}, {31'd0, e.bit_v});
               end
               last_exp = e.bit_v;
               if (zero_mode) check("pm0_zero", {24'd0, dut.pm[0]}, 32'd0);
            end
         end else begin
            check("hold_d_out", {31'd0, d_out}, {31'd0, last_exp});
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b0;
      #1;
      check("reset_pm0", {24'd0, dut.pm[0]}, 32'd0);
      check("reset_pm1", {24'd0, dut.pm[1]}, 32'd64);
      check("reset_pm3", {24'd0, dut.pm[3]}, 32'd64);
      exp_q.delete();
      u_hist.delete();
      enc_st = 2'b00;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic send(input logic u, input logic [1:0] flip);
      logic [1:0] sym;
      int idx;
      exp_t e;
      @(negedge clk);
      sym = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[0]} ^ flip;
      enc_st = {u, enc_st[1]};
      u_hist.push_back(u);
      idx = u_hist.size() - 1 - TB_DEPTH;
      e.bit_v = (idx >= 0) ? u_hist[idx] : 1'b0;
      e.tol = (idx >= tol_lo) && (idx <= tol_hi);
      exp_q.push_back(e);
      d_in = sym;
      enable = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         enable = 1'b0;
         d_in = 2'($urandom);
      end
   endtask

   initial begin
      do_reset();

      // clean random stream
      for (int i = 0; i < 256; i++) send(1'($urandom), 2'b00);
      idle(2);

      // all-zero stream, path metric of state 0 must stay 0
      do_reset();
      zero_mode = 1'b1;
      for (int i = 0; i < 100; i++) send(1'b0, 2'b00);
      idle(1);
      zero_mode = 1'b0;

      // isolated single-bit errors on d_in[0], one every 8 symbols
      do_reset();
      for (int i = 0; i < 256; i++) send(1'($urandom), (i % 8 == 3) ? 2'b01 : 2'b00);
      idle(2);

      // two adjacent corrupted symbols, small decoded-error budget nearby
      do_reset();
      tol_lo = 26;
      tol_hi = 41;
      for (int i = 0; i < 64; i++) send(1'($urandom), (i == 30 || i == 31) ? 2'b01 : 2'b00);
      idle(2);
      tol_lo = -1000;
      tol_hi = -1000;
      check("adjacent_err_budget", {31'd0, (tol_err <= 2)}, 32'd1);

      // idle gaps between symbols
      do_reset();
      for (int i = 0; i < 128; i++) begin
         send(1'($urandom), 2'b00);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
      end
      idle(2);

      // reset in the middle of a stream, then restart from index 0
      do_reset();
      for (int i = 0; i < 40; i++) send(1'($urandom), 2'b00);
      do_reset();
      for (int i = 0; i < 60; i++) send(1'($urandom), 2'b00);
      idle(3);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
